decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
- Parametrised successor to the decode-stage register-read control.
- Decodes the D-stage opcode into regfile read-port selects and read addresses.
- Detects load-use hazards against the instruction held in X and generates the D-stage stall.
- Owns the D/X control pipeline register (valid, write-enable, destination, load flag) and a saturating stall-cycle counter for performance debug.

Parameters:
- OPC_W, 5, opcode width
- RA_W, 5, register address width
- RSTATUS, 30, register read by bex and written by setx
- RLINK, 31, register written by jal
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- insn_valid_d  in  1  D-stage instruction valid
- opcode_d  in  OPC_W  D-stage opcode
- rd_d  in  RA_W  rd field
- rs_d  in  RA_W  rs field
- rt_d  in  RA_W  rt field
- stall_ext  in  1  downstream hold; D/X register keeps its value
- flush  in  1  branch/jump flush; kills the D/X entry
- regfile_s1  out  1  port-A select: 1 selects RSTATUS
- regfile_s2  out  1  port-B select: 1 selects rd
- raddr_a  out  RA_W  port-A address
- raddr_b  out  RA_W  port-B address
- stall_d  out  1  load-use stall request to fetch/decode
- valid_x  out  1  X-stage instruction valid
- wen_x  out  1  X-stage instruction writes the regfile
- dest_x  out  RA_W  X-stage destination register
- load_x  out  1  X-stage instruction is lw
- stall_cnt  out  CNT_W  saturating count of stall_d cycles

Behaviour:
- Opcodes:
  - 00000 R-type
  - 00001 j
  - 00010 bne
  - 00011 jal
  - 00100 jr
  - 00101 addi
  - 00110 blt
  - 00111 sw
  - 01000 lw
  - 10101 setx
  - 10110 bex
  - All others are NOP-like: no reads, no writes.
- Combinational selects and addresses:
  - regfile_s1 = (opcode_d == bex).
  - regfile_s2 = opcode_d in {sw, bne, jr, blt}.
  - raddr_a = regfile_s1 ? RSTATUS : rs_d.
  - raddr_b = regfile_s2 ? rd_d : rt_d.
- Port usage:
  - Port A is used by R-type, addi, lw, sw, bne, blt, bex.
  - Port B is used by R-type, sw, bne, jr, blt.
- Hazard detection:
  - stall_d = insn_valid_d & valid_x & load_x & (dest_x != 0) & ((useA & raddr_a == dest_x) | (useB & raddr_b == dest_x)).
  - stall_d is purely combinational and is forced to 0 while flush = 1.
- Next-state decode for the D/X register:
  - wen: set for R-type, addi, lw, jal, setx.
  - dest: RLINK for jal, RSTATUS for setx, else rd_d.
  - dest is forced to 0 and wen cleared when the destination is r0.
  - load = (opcode_d == lw).
- D/X register update on each rising clock edge, in priority order:
  1. flush: valid_x = 0, wen_x = 0, load_x = 0, dest_x = 0.
  2. stall_ext: all D/X outputs hold.
  3. stall_d: bubble inserted; fields cleared as in flush.
  4. Otherwise: load the decoded fields, with valid_x = insn_valid_d.
  - If insn_valid_d = 0, wen and load are also cleared.
- stall_cnt:
  - Increments on each cycle with stall_d = 1 and stall_ext = 0.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Reset (reset_n low, asynchronous, any time including mid-stall): valid_x, wen_x, load_x, dest_x and stall_cnt all go to 0 immediately. Combinational outputs follow their inputs.
- Stall duration:
  - A load-use stall lasts exactly one cycle: the bubble clears load_x, so stall_d drops.
  - Under stall_ext the X entry is held, so stall_d may persist, but stall_cnt does not advance.

Test Plan:
1. Decode selects: opcode 10110, rs = 4 -> regfile_s1 = 1, raddr_a = 30. Opcode 00111, rd = 7, rt = 3 -> regfile_s2 = 1, raddr_b = 7. Opcode 00000 -> both selects 0, raddr_a = rs, raddr_b = rt.
2. Load-use: lw rd = 5 enters X; next D is add rs = 5 -> stall_d = 1 for one cycle, bubble in X (valid_x = 0), then the add advances; stall_cnt = 1.
3. No false stall:
   - lw rd = 0 followed by add rs = 0 -> stall_d = 0.
   - addi rd = 5 followed by add rs = 5 -> stall_d = 0.
   - lw rd = 5 followed by j (no reads) -> stall_d = 0.
4. Destination mapping: jal -> dest_x = 31, wen_x = 1. setx -> dest_x = 30. sw -> wen_x = 0.
5. Priority:
   - flush asserted during a load-use stall -> stall_d = 0, valid_x = 0 next edge, stall_cnt unchanged.
   - stall_ext = 1 with a valid X entry -> D/X outputs unchanged over 3 cycles.
6. Reset and saturation:
   - Drive reset_n low mid-stall -> all registered outputs 0 without waiting for a clock edge.
   - With CNT_W = 2, force 5 stall cycles -> stall_cnt = 3.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// Decode-stage register-read control: read-port selects/addresses, load-use
// hazard detection, the D/X control pipeline register and a stall counter.
module decode_ctrl_pipe #(
    parameter int OPC_W   = 5,
    parameter int RA_W    = 5,
    parameter int RSTATUS = 30,
    parameter int RLINK   = 31,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             insn_valid_d,
    input  logic [OPC_W-1:0] opcode_d,
    input  logic [RA_W-1:0]  rd_d,
    input  logic [RA_W-1:0]  rs_d,
    input  logic [RA_W-1:0]  rt_d,
    input  logic             stall_ext,
    input  logic             flush,
    output logic             regfile_s1,
    output logic             regfile_s2,
    output logic [RA_W-1:0]  raddr_a,
    output logic [RA_W-1:0]  raddr_b,
    output logic             stall_d,
    output logic             valid_x,
    output logic             wen_x,
    output logic [RA_W-1:0]  dest_x,
    output logic             load_x,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_JR    = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_BLT   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SETX  = OPC_W'(21);
    localparam logic [OPC_W-1:0] OP_BEX   = OPC_W'(22);

    localparam logic [RA_W-1:0]  A_STATUS = RA_W'(RSTATUS);
    localparam logic [RA_W-1:0]  A_LINK   = RA_W'(RLINK);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             w_use_a;
    logic             w_use_b;
    logic             w_sel_a;
    logic             w_sel_b;
    logic             w_wen_op;
    logic [RA_W-1:0]  w_dest_raw;
    logic [RA_W-1:0]  w_dest;
    logic             w_wen;
    logic             w_load;
    logic [RA_W-1:0]  w_raddr_a;
    logic [RA_W-1:0]  w_raddr_b;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_stall;

    logic             r_valid_x;
    logic             r_wen_x;
    logic [RA_W-1:0]  r_dest_x;
    logic             r_load_x;
    logic [CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_use_a    = 1'b0;
        w_use_b    = 1'b0;
        w_sel_a    = 1'b0;
        w_sel_b    = 1'b0;
        w_wen_op   = 1'b0;
        w_dest_raw = rd_d;
        unique case (opcode_d)
            OP_RTYPE: begin w_use_a = 1'b1; w_use_b = 1'b1; w_wen_op = 1'b1; end
            OP_J:     ;
            OP_BNE:   begin w_use_a = 1'b1; w_use_b = 1'b1; w_sel_b = 1'b1; end
            OP_JAL:   begin w_wen_op = 1'b1; w_dest_raw = A_LINK; end
            OP_JR:    begin w_use_b = 1'b1; w_sel_b = 1'b1; end
            OP_ADDI:  begin w_use_a = 1'b1; w_wen_op = 1'b1; end
            OP_BLT:   begin w_use_a = 1'b1; w_use_b = 1'b1; w_sel_b = 1'b1; end
            OP_SW:    begin w_use_a = 1'b1; w_use_b = 1'b1; w_sel_b = 1'b1; end
            OP_LW:    begin w_use_a = 1'b1; w_wen_op = 1'b1; end
            OP_SETX:  begin w_wen_op = 1'b1; w_dest_raw = A_STATUS; end
            OP_BEX:   begin w_use_a = 1'b1; w_sel_a = 1'b1; end
            default:  ;
        endcase
    end

    assign w_raddr_a = w_sel_a ? A_STATUS : rs_d;
    assign w_raddr_b = w_sel_b ? rd_d : rt_d;

    // r0 is never a real destination, so it never causes a write or a hazard.
    assign w_dest = (w_dest_raw == '0) ? '0 : w_dest_raw;
    assign w_wen  = insn_valid_d & w_wen_op & (w_dest != '0);
    assign w_load = insn_valid_d & (opcode_d == OP_LW);

    assign w_hit_a = w_use_a & (w_raddr_a == r_dest_x);
    assign w_hit_b = w_use_b & (w_raddr_b == r_dest_x);
    assign w_stall = ~flush & insn_valid_d & r_valid_x & r_load_x
                   & (r_dest_x != '0) & (w_hit_a | w_hit_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_x <= 1'b0;
            r_wen_x   <= 1'b0;
            r_dest_x  <= '0;
            r_load_x  <= 1'b0;
        end else if (flush || (!stall_ext && w_stall)) begin
            r_valid_x <= 1'b0;
            r_wen_x   <= 1'b0;
            r_dest_x  <= '0;
            r_load_x  <= 1'b0;
        end else if (!stall_ext) begin
            r_valid_x <= insn_valid_d;
            r_wen_x   <= w_wen;
            r_dest_x  <= w_dest;
            r_load_x  <= w_load;
        end
    end

    // Counts only cycles the stall actually costs; a downstream hold masks it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !stall_ext && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign regfile_s1 = w_sel_a;
    assign regfile_s2 = w_sel_b;
    assign raddr_a    = w_raddr_a;
    assign raddr_b    = w_raddr_b;
    assign stall_d    = w_stall;
    assign valid_x    = r_valid_x;
    assign wen_x      = r_wen_x;
    assign dest_x     = r_dest_x;
    assign load_x     = r_load_x;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: a default instance and a CNT_W=2 instance share
// stimulus; a reference model pushes expectations that a monitor pops and checks.
module tb_decode_ctrl_pipe;

    localparam int OP_R = 0, OP_J = 1, OP_BNE = 2, OP_JAL = 3, OP_JR = 4, OP_ADDI = 5;
    localparam int OP_BLT = 6, OP_SW = 7, OP_LW = 8, OP_SETX = 21, OP_BEX = 22, OP_NOP = 31;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        insn_valid_d = 1'b0;
    logic [4:0]  opcode_d = '0;
    logic [4:0]  rd_d = '0, rs_d = '0, rt_d = '0;
    logic        stall_ext = 1'b0, flush = 1'b0;

    logic        regfile_s1, regfile_s2, stall_d, valid_x, wen_x, load_x;
    logic [4:0]  raddr_a, raddr_b, dest_x;
    logic [15:0] stall_cnt;
    logic        s_s1, s_s2, s_stall, s_valid, s_wen, s_load;
    logic [4:0]  s_ra, s_rb, s_dest;
    logic [1:0]  s_cnt;

    always #5 clock = ~clock;

    decode_ctrl_pipe dut (
        .clock(clock), .reset_n(reset_n), .insn_valid_d(insn_valid_d), .opcode_d(opcode_d),
        .rd_d(rd_d), .rs_d(rs_d), .rt_d(rt_d), .stall_ext(stall_ext), .flush(flush),
        .regfile_s1(regfile_s1), .regfile_s2(regfile_s2), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .stall_d(stall_d), .valid_x(valid_x), .wen_x(wen_x), .dest_x(dest_x), .load_x(load_x),
        .stall_cnt(stall_cnt)
    );

    decode_ctrl_pipe #(.CNT_W(2)) dut_small (
        .clock(clock), .reset_n(reset_n), .insn_valid_d(insn_valid_d), .opcode_d(opcode_d),
        .rd_d(rd_d), .rs_d(rs_d), .rt_d(rt_d), .stall_ext(stall_ext), .flush(flush),
        .regfile_s1(s_s1), .regfile_s2(s_s2), .raddr_a(s_ra), .raddr_b(s_rb),
        .stall_d(s_stall), .valid_x(s_valid), .wen_x(s_wen), .dest_x(s_dest), .load_x(s_load),
        .stall_cnt(s_cnt)
    );

    typedef struct packed {
        logic        s1;
        logic        s2;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        stall;
        logic        valid;
        logic        wen;
        logic [4:0]  dest;
        logic        load;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   done = 0;
    int   cycle = 0;

    // Reference model: the instruction sitting in X and the raw stall count.
    bit m_valid = 0, m_wen = 0, m_load = 0;
    int m_dest = 0;
    int m_count = 0;

    function automatic bit reads_a(input int op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_BEX};
    endfunction

    function automatic bit reads_b(input int op);
        return op inside {OP_R, OP_SW, OP_BNE, OP_JR, OP_BLT};
    endfunction

    function automatic bit b_is_rd(input int op);
        return op inside {OP_SW, OP_BNE, OP_JR, OP_BLT};
    endfunction

    function automatic bit writes(input int op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_JAL, OP_SETX};
    endfunction

    task automatic drive(input bit iv, input int op, input int rd, input int rs, input int rt,
                         input bit sx, input bit fl, input bit rst, output bit stalled);
        exp_t e;
        int   ra, rb, dest;
        bit   st;
        @(posedge clock);
        #2;
        reset_n      = rst;
        insn_valid_d = iv;
        opcode_d     = op[4:0];
        rd_d         = rd[4:0];
        rs_d         = rs[4:0];
        rt_d         = rt[4:0];
        stall_ext    = sx;
        flush        = fl;
        cycle++;
        if (!rst) begin
            m_valid = 0; m_wen = 0; m_load = 0; m_dest = 0; m_count = 0;
        end
        ra = (op == OP_BEX) ? 30 : rs;
        rb = b_is_rd(op) ? rd : rt;
        st = !fl && iv && m_valid && m_load && (m_dest != 0) &&
             ((reads_a(op) && ra == m_dest) || (reads_b(op) && rb == m_dest));
        e.s1    = (op == OP_BEX);
        e.s2    = b_is_rd(op);
        e.ra    = ra[4:0];
        e.rb    = rb[4:0];
        e.stall = st;
        e.valid = m_valid;
        e.wen   = m_wen;
        e.dest  = m_dest[4:0];
        e.load  = m_load;
        e.cnt   = 16'((m_count > 65535) ? 65535 : m_count);
        e.cnt2  = 2'((m_count > 3) ? 3 : m_count);
        exp_q.push_back(e);
        if (rst) begin
            if (st && !sx) m_count++;
            if (fl || (st && !sx)) begin
                m_valid = 0; m_wen = 0; m_load = 0; m_dest = 0;
            end else if (!sx) begin
                dest    = (op == OP_JAL) ? 31 : (op == OP_SETX) ? 30 : rd;
                m_valid = iv;
                m_wen   = iv && writes(op) && (dest != 0);
                m_dest  = dest;
                m_load  = iv && (op == OP_LW);
            end
        end
        stalled = st;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle, act, exp);
        end
    endtask

    // Monitor: outputs are present every cycle; sample mid-cycle, away from edges.
    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("regfile_s1", 32'(regfile_s1), 32'(e.s1));
                check("regfile_s2", 32'(regfile_s2), 32'(e.s2));
                check("raddr_a", 32'(raddr_a), 32'(e.ra));
                check("raddr_b", 32'(raddr_b), 32'(e.rb));
                check("stall_d", 32'(stall_d), 32'(e.stall));
                check("valid_x", 32'(valid_x), 32'(e.valid));
                check("wen_x", 32'(wen_x), 32'(e.wen));
                check("dest_x", 32'(dest_x), 32'(e.dest));
                check("load_x", 32'(load_x), 32'(e.load));
                check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
                check("stall_cnt_w2", 32'(s_cnt), 32'(e.cnt2));
                check("small_stall_d", 32'(s_stall), 32'(e.stall));
                check("small_dest_x", 32'(s_dest), 32'(e.dest));
            end
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stimulus
        bit st;
        bit held;
        int op_tab[12];
        int c_op, c_rd, c_rs, c_rt, sel;
        bit c_iv, sx, fl, rst;
        op_tab = '{OP_R, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX, OP_NOP};

        drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, st);
        drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, st);
        // Decode selects
        drive(1, OP_BEX, 1, 4, 2, 0, 0, 1, st);
        drive(1, OP_SW, 7, 1, 3, 0, 0, 1, st);
        drive(1, OP_R, 9, 1, 2, 0, 0, 1, st);
        // Load-use: stall, bubble, then the add advances
        drive(1, OP_LW, 5, 1, 0, 0, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 0, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 0, 0, 1, st);
        drive(1, OP_J, 0, 0, 0, 0, 0, 1, st);
        // No false stalls
        drive(1, OP_LW, 0, 1, 0, 0, 0, 1, st);
        drive(1, OP_R, 3, 0, 0, 0, 0, 1, st);
        drive(1, OP_ADDI, 5, 1, 0, 0, 0, 1, st);
        drive(1, OP_R, 3, 5, 5, 0, 0, 1, st);
        drive(1, OP_LW, 5, 1, 0, 0, 0, 1, st);
        drive(1, OP_J, 5, 5, 5, 0, 0, 1, st);
        // Destination mapping
        drive(1, OP_JAL, 2, 0, 0, 0, 0, 1, st);
        drive(1, OP_SETX, 2, 0, 0, 0, 0, 1, st);
        drive(1, OP_SW, 9, 1, 2, 0, 0, 1, st);
        drive(0, OP_NOP, 0, 0, 0, 0, 0, 1, st);
        // Flush during a load-use stall
        drive(1, OP_LW, 5, 1, 0, 0, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 0, 1, 1, st);
        drive(1, OP_R, 6, 1, 2, 0, 0, 1, st);
        // stall_ext holds a valid X entry for 3 cycles
        drive(1, OP_ADDI, 8, 1, 0, 0, 0, 1, st);
        for (int i = 0; i < 3; i++) drive(1, OP_JAL, 1, 2, 3, 1, 0, 1, st);
        drive(1, OP_J, 0, 0, 0, 0, 0, 1, st);
        // Held stall under stall_ext, then reset mid-stall
        drive(1, OP_LW, 5, 1, 0, 0, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 1, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 1, 0, 1, st);
        drive(1, OP_R, 6, 5, 2, 1, 0, 0, st);
        drive(1, OP_R, 6, 5, 2, 0, 0, 1, st);
        // Five stalls saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1, OP_LW, 5, 1, 0, 0, 0, 1, st);
            drive(1, OP_R, 6, 5, 5, 0, 0, 1, st);
            drive(1, OP_R, 6, 5, 5, 0, 0, 1, st);
        end

        // Random traffic; a stalled or held D instruction is re-presented.
        held = 0;
        c_iv = 1; c_op = OP_NOP; c_rd = 0; c_rs = 0; c_rt = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!held) begin
                sel  = $urandom_range(0, 15);
                c_op = (sel > 11) ? OP_LW : op_tab[sel];
                c_iv = ($urandom_range(0, 9) != 0);
                c_rd = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 7);
                c_rs = $urandom_range(0, 7);
                c_rt = $urandom_range(0, 7);
            end
            sx  = ($urandom_range(0, 6) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) != 0);
            drive(c_iv, c_op, c_rd, c_rs, c_rt, sx, fl, rst, st);
            held = rst && !fl && (st || sx);
        end
        @(posedge clock);
        done = 1;
    end

endmodule
